// File: rtl/aes_dec_pkg.sv
// Shared types and GF(2^8) helpers for the AES-128 decryption core.
package aes_dec_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BLOCK_W = 128;

  typedef enum logic [1:0] {StIdle, StExpand, StDecrypt, StDone} state_e;

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul09(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] mul0b(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] mul0d(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] mul0e(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] y, r;
    y = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      y = gf_mul(y, y);
      r = gf_mul(r, y);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round; last bypasses InvMixColumns.
module aes_inv_round
  import aes_dec_pkg::*;
(
  input  logic [BLOCK_W-1:0] state,
  input  logic [BLOCK_W-1:0] round_key,
  input  logic               last,
  output logic [BLOCK_W-1:0] result
);

  logic [7:0] w_sr  [16];
  logic [7:0] w_sb  [16];
  logic [7:0] w_ark [16];
  logic [7:0] w_mc  [16];

  for (genvar i = 0; i < 16; i++) begin : g_byte
    localparam int Row = i % 4;
    localparam int Col = i / 4;
    // Row r of column c comes from column (c - r) mod 4.
    localparam int Src = 4 * ((Col - Row + 4) % 4) + Row;

    assign w_sr[i] = state[BLOCK_W-1-8*Src -: 8];

    sbox_combi u_sbox (
      .en_or_de (1'b0),
      .i_data   (w_sr[i]),
      .o_data   (w_sb[i])
    );

    assign w_ark[i] = w_sb[i] ^ round_key[BLOCK_W-1-8*i -: 8];
    assign result[BLOCK_W-1-8*i -: 8] = last ? w_ark[i] : w_mc[i];
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign w_mc[4*c+0] = mul0e(w_ark[4*c]) ^ mul0b(w_ark[4*c+1])
                       ^ mul0d(w_ark[4*c+2]) ^ mul09(w_ark[4*c+3]);
    assign w_mc[4*c+1] = mul09(w_ark[4*c]) ^ mul0e(w_ark[4*c+1])
                       ^ mul0b(w_ark[4*c+2]) ^ mul0d(w_ark[4*c+3]);
    assign w_mc[4*c+2] = mul0d(w_ark[4*c]) ^ mul09(w_ark[4*c+1])
                       ^ mul0e(w_ark[4*c+2]) ^ mul0b(w_ark[4*c+3]);
    assign w_mc[4*c+3] = mul0b(w_ark[4*c]) ^ mul0d(w_ark[4*c+1])
                       ^ mul09(w_ark[4*c+2]) ^ mul0e(w_ark[4*c+3]);
  end

endmodule

// File: rtl/sbox_combi.sv
// Combinational AES S-box: en_or_de = 1 forward SubBytes, 0 inverse SubBytes.
module sbox_combi
  import aes_dec_pkg::*;
(
  input  logic       en_or_de,
  input  logic [7:0] i_data,
  output logic [7:0] o_data
);

  logic [7:0] w_pre;
  logic [7:0] w_inv;
  logic [7:0] w_aff;

  // One shared inversion: inverse affine before it, forward affine after it.
  assign w_pre = en_or_de ? i_data
                          : (rotl8(i_data, 1) ^ rotl8(i_data, 3) ^ rotl8(i_data, 6) ^ 8'h05);
  assign w_inv = gf_inv(w_pre);
  assign w_aff = w_inv ^ rotl8(w_inv, 1) ^ rotl8(w_inv, 2) ^ rotl8(w_inv, 3)
               ^ rotl8(w_inv, 4) ^ 8'h63;
  assign o_data = en_or_de ? w_aff : w_inv;

endmodule

// File: rtl/aes128_decrypt_core.sv
// Iterative AES-128 decryption: 10-cycle forward key expansion, then 10 inverse rounds.
module aes128_decrypt_core
  import aes_dec_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] ciphertext,
  input  logic [BLOCK_W-1:0] key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] plaintext
);

  state_e             r_fsm;
  logic [3:0]         r_rcnt;
  logic [BLOCK_W-1:0] r_state;
  logic [BLOCK_W-1:0] r_key;

  logic [WORD_W-1:0]  w_w0, w_w1, w_w2, w_w3;
  logic [WORD_W-1:0]  w_w3_prev;
  logic [WORD_W-1:0]  w_sub_in;
  logic [WORD_W-1:0]  w_rot;
  logic [WORD_W-1:0]  w_sub;
  logic [WORD_W-1:0]  w_t;
  logic [3:0]         w_rc_idx;
  logic [WORD_W-1:0]  w_f0, w_f1, w_f2, w_f3;
  logic [BLOCK_W-1:0] w_key_fwd;
  logic [BLOCK_W-1:0] w_key_rev;
  logic [BLOCK_W-1:0] w_round;

  assign w_w0 = r_key[BLOCK_W-1            -: WORD_W];
  assign w_w1 = r_key[BLOCK_W-1-WORD_W     -: WORD_W];
  assign w_w2 = r_key[BLOCK_W-1-2*WORD_W   -: WORD_W];
  assign w_w3 = r_key[WORD_W-1:0];

  // Reverse step needs w3 of k(r), recovered as w3' ^ w2' before SubWord.
  assign w_w3_prev = w_w3 ^ w_w2;
  assign w_sub_in  = (r_fsm == StDecrypt) ? w_w3_prev : w_w3;
  assign w_rc_idx  = (r_fsm == StDecrypt) ? 4'(r_rcnt + 4'd1) : r_rcnt;
  assign w_rot     = {w_sub_in[23:0], w_sub_in[31:24]};

  for (genvar j = 0; j < 4; j++) begin : g_ksbox
    sbox_combi u_sbox (
      .en_or_de (1'b1),
      .i_data   (w_rot[8*j +: 8]),
      .o_data   (w_sub[8*j +: 8])
    );
  end

  assign w_t  = w_sub ^ {rcon(w_rc_idx), 24'h000000};

  assign w_f0 = w_w0 ^ w_t;
  assign w_f1 = w_w1 ^ w_f0;
  assign w_f2 = w_w2 ^ w_f1;
  assign w_f3 = w_w3 ^ w_f2;
  assign w_key_fwd = {w_f0, w_f1, w_f2, w_f3};

  assign w_key_rev = {w_w0 ^ w_t, w_w1 ^ w_w0, w_w2 ^ w_w1, w_w3_prev};

  aes_inv_round u_round (
    .state     (r_state),
    .round_key (w_key_rev),
    .last      (r_rcnt == 4'd0),
    .result    (w_round)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm   <= StIdle;
      r_rcnt  <= 4'd0;
      r_state <= '0;
      r_key   <= '0;
    end else begin
      case (r_fsm)
        StIdle: begin
          if (in_valid) begin
            r_state <= ciphertext;
            r_key   <= key;
            r_rcnt  <= 4'd1;
            r_fsm   <= StExpand;
          end
        end
        StExpand: begin
          r_key <= w_key_fwd;
          if (r_rcnt == 4'd10) begin
            r_state <= r_state ^ w_key_fwd;
            r_rcnt  <= 4'd9;
            r_fsm   <= StDecrypt;
          end else begin
            r_rcnt <= r_rcnt + 4'd1;
          end
        end
        StDecrypt: begin
          r_key   <= w_key_rev;
          r_state <= w_round;
          if (r_rcnt == 4'd0) r_fsm <= StDone;
          else                r_rcnt <= r_rcnt - 4'd1;
        end
        StDone: begin
          if (out_ready) r_fsm <= StIdle;
        end
        default: r_fsm <= StIdle;
      endcase
    end
  end

  assign in_ready  = (r_fsm == StIdle);
  assign out_valid = (r_fsm == StDone);
  assign plaintext = r_state;

endmodule

// File: tb/tb_aes128_decrypt_core.sv
// Directed and randomized checks of aes128_decrypt_core against a table-driven AES model.
module tb_aes128_decrypt_core;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ciphertext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plaintext;

  int tests = 0;
  int fails = 0;

  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  localparam logic [127:0] C1Key = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1Ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1Pt  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] BKey  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] BCt   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] BPt   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] BK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  always #5 clk = ~clk;

  aes128_decrypt_core dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ciphertext (ciphertext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .plaintext  (plaintext)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Walks generator 3 and its inverse together to fill the S-box tables.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl(q, 1) ^ rotl(q, 2) ^ rotl(q, 3) ^ rotl(q, 4);
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
  endtask

  function automatic logic [127:0] round_key(input logic [127:0] k, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] model_decrypt(input logic [127:0] k, input logic [127:0] c);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] rk;
    logic [127:0] blk;
    blk = c ^ round_key(k, 10);
    for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8];
    for (int r = 9; r >= 0; r--) begin
      rk = round_key(k, r);
      for (int i = 0; i < 16; i++) t[i] = s[(i % 4) + 4 * (((i / 4) - (i % 4) + 4) % 4)];
      for (int i = 0; i < 16; i++) s[i] = isb[t[i]] ^ rk[127-8*i -: 8];
      if (r > 0) begin
        for (int c4 = 0; c4 < 4; c4++) begin
          for (int j = 0; j < 4; j++) t[j] = s[4*c4+j];
          for (int j = 0; j < 4; j++)
            s[4*c4+j] = gmul(t[j], 8'h0e) ^ gmul(t[(j+1)%4], 8'h0b)
                      ^ gmul(t[(j+2)%4], 8'h0d) ^ gmul(t[(j+3)%4], 8'h09);
        end
      end
    end
    for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = s[i];
    return blk;
  endfunction

  task automatic run_block(input string tag, input logic [127:0] k, input logic [127:0] c,
                           input logic [127:0] exp_pt, input int hold, input bit scramble);
    int           lat = 0;
    logic [127:0] k10;
    k10        = round_key(k, 10);
    key        = k;
    ciphertext = c;
    in_valid   = 1'b1;
    out_ready  = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && lat < 40) begin
      if (scramble) begin
        in_valid   = 1'($urandom);
        ciphertext = {$urandom, $urandom, $urandom, $urandom};
        key        = {$urandom, $urandom, $urandom, $urandom};
      end
      @(posedge clk); #1;
      lat++;
      if (lat == 10) check({tag, " k10"}, dut.r_key, k10);
    end
    in_valid = 1'b0;
    check({tag, " latency"}, 128'(lat), 128'd20);
    check({tag, " plaintext"}, plaintext, exp_pt);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold pt"}, plaintext, exp_pt);
      check({tag, " hold ready/valid"}, {126'd0, in_ready, out_valid}, 128'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " back to idle"}, {126'd0, in_ready, out_valid}, 128'd2);
  endtask

  initial begin
    int           pulses;
    int           cyc;
    bit           rdy;
    int           acc [$];
    logic [127:0] res [$];
    logic [127:0] rk, rc;

    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    key        = '0;
    ciphertext = '0;
    build_sbox();

    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 128'(in_ready), 128'd1);
    check("reset out_valid", 128'(out_valid), 128'd0);
    check("reset plaintext", plaintext, 128'd0);
    check("reset key reg", dut.r_key, 128'd0);
    check("reset rcnt", 128'(dut.r_rcnt), 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_block("c1", C1Key, C1Ct, C1Pt, 0, 1'b0);
    run_block("appB", BKey, BCt, BPt, 15, 1'b0);
    check("appB model k10", round_key(BKey, 10), BK10);
    run_block("c1 scrambled", C1Key, C1Ct, C1Pt, 0, 1'b1);

    // Reset in the middle of a C.1 block.
    key        = C1Key;
    ciphertext = C1Ct;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst in_ready", 128'(in_ready), 128'd1);
    check("midrst out_valid", 128'(out_valid), 128'd0);
    check("midrst plaintext", plaintext, 128'd0);
    check("midrst key reg", dut.r_key, 128'd0);
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    check("midrst no out_valid", 128'(pulses), 128'd0);
    run_block("c1 after rst", C1Key, C1Ct, C1Pt, 0, 1'b0);

    // Back-to-back with in_valid and out_ready high.
    key        = C1Key;
    ciphertext = C1Ct;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    cyc        = 0;
    while (res.size() < 2 && cyc < 100) begin
      rdy = in_ready;
      @(posedge clk); #1;
      cyc++;
      if (rdy && in_valid) begin
        acc.push_back(cyc);
        if (acc.size() == 1) begin
          key        = BKey;
          ciphertext = BCt;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) res.push_back(plaintext);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("b2b accept count", 128'(acc.size()), 128'd2);
    check("b2b spacing", 128'(acc.size() == 2 ? acc[1] - acc[0] : 0), 128'd22);
    check("b2b pt0", res.size() > 0 ? res[0] : 128'd0, C1Pt);
    check("b2b pt1", res.size() > 1 ? res[1] : 128'd0, BPt);

    for (int n = 0; n < 4; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rc = {$urandom, $urandom, $urandom, $urandom};
      run_block("random", rk, rc, model_decrypt(rk, rc), n, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
